// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: presents round keys 0..10 one per
// valid/ready transfer, holding only the current round key.
module aes_key_expand (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0][7:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_round,
    output logic [15:0][7:0] rk
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx  = {~b, 3'b000};
        sbox = SBOX_TBL[idx +: 8];
    endfunction

    state_t state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [15:0][7:0] key_q, key_d;
    logic [15:0][7:0] key_nxt;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, t;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon;
    logic        xfer;

    // Rcon for the key being produced, i.e. Rcon[round+1].
    always_comb begin
        rcon = 8'h00;
        unique case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0  = key_q[15:12];
    assign w1  = key_q[11:8];
    assign w2  = key_q[7:4];
    assign w3  = key_q[3:0];
    assign rot = {w3[23:0], w3[31:24]};

    assign t = {sbox(rot[31:24]) ^ rcon,
                sbox(rot[23:16]),
                sbox(rot[15:8]),
                sbox(rot[7:0])};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_nxt = {n0, n1, n2, n3};
    assign xfer    = (state_q == RUN) & rk_ready;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (round_q == 4'd10) begin
                        state_d = IDLE;
                    end else begin
                        key_d   = key_nxt;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            key_q   <= key_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign rk_valid = (state_q == RUN);
    assign rk_round = round_q;
    assign rk       = key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 schedule model built from GF(2^8)
// arithmetic, checked every cycle against the DUT.
module tb_aes_key_expand;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [15:0][7:0] key_in;
    logic             busy;
    logic             rk_valid;
    logic             rk_ready;
    logic [3:0]       rk_round;
    logic [15:0][7:0] rk;

    int checks   = 0;
    int failures = 0;

    aes_key_expand dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk       (rk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KZ = 128'h0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------- reference model from the algebraic definition ----------
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
               ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    logic [7:0] sbt [256];
    initial for (int i = 0; i < 256; i++) sbt[i] = sb(8'(i));

    function automatic logic [127:0] round_key(input logic [127:0] key,
                                               input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]],
                       sbt[tmp[15:8]], sbt[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------- behavioural transaction model ----------
    logic         mvalid;
    int           mround;
    logic [127:0] mkeys [11];
    int           nxfer = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mvalid <= 1'b0;
            mround <= 0;
        end else begin
            if (rk_valid && rk_ready) nxfer <= nxfer + 1;
            if (!mvalid) begin
                if (start) begin
                    for (int r = 0; r < 11; r++)
                        mkeys[r] <= round_key(key_in, r);
                    mround <= 0;
                    mvalid <= 1'b1;
                end
            end else if (rk_ready) begin
                if (mround == 10) mvalid <= 1'b0;
                else mround <= mround + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 128'(busy), 128'(mvalid));
            check("rk_valid", 128'(rk_valid), 128'(mvalid));
            if (mvalid) begin
                check("rk_round", 128'(rk_round), 128'(mround));
                check("rk", rk, mkeys[mround]);
            end
        end
    end

    // ---------- stimulus helpers ----------
    task automatic wait_round(input int r);
        int n = 0;
        while (!(rk_valid && rk_round == 4'(r)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_round_timeout", 128'(n >= 200), 128'(0));
    endtask

    task automatic run_full(input logic [127:0] key, input bit bp,
                            input string tag);
        int base;
        int cyc = 0;
        base = nxfer;
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        if (!bp) rk_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~key;
        while (busy && cyc < 600) begin
            if (bp) begin
                if (cyc == 4 || cyc == 30) rk_ready = 1'b0;
                else if ((cyc > 4 && cyc < 24) || (cyc > 30 && cyc < 45))
                    rk_ready = 1'b0;
                else rk_ready = ($urandom_range(0, 9) < 4);
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 128'(cyc >= 600), 128'(0));
        check({tag, "_xfers"}, 128'(nxfer - base), 128'(11));
        if (!bp) check({tag, "_cycles"}, 128'(cyc), 128'(11));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        #3;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_round", 128'(rk_round), 128'(0));
        check("rst_rk", rk, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // idle with ready wandering
        repeat (20) begin
            @(negedge clk);
            rk_ready = 1'($urandom_range(0, 1));
        end

        // pin the model to known FIPS-197 values
        check("model_k1_r1", round_key(K1, 1),
              128'ha0fafe1788542cb123a339392a6c7605);
        check("model_k1_r10", round_key(K1, 10),
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_kz_r1", round_key(KZ, 1),
              128'h62636363626363636263636362636363);
        check("model_kz_r10", round_key(KZ, 10),
              128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_full(K1, 1'b0, "fips");
        run_full(KZ, 1'b0, "zero");
        run_full(K1, 1'b1, "bp");

        // start during RUN ignored; restart right after final transfer
        @(negedge clk);
        rk_ready = 1'b1;
        key_in   = K1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        key_in = K2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_round(10);
        check("r10_key", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key_in = K2;
        start  = 1'b1;
        @(negedge clk);
        check("after_final_busy", 128'(busy), 128'(0));
        @(negedge clk);
        start = 1'b0;
        check("restart_valid", 128'(rk_valid), 128'(1));
        check("restart_round", 128'(rk_round), 128'(0));
        check("restart_rk", rk, K2);
        wait_round(10);
        @(negedge clk);

        // asynchronous reset mid-expansion
        key_in = K1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_round(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_valid", 128'(rk_valid), 128'(0));
        check("midrst_round", 128'(rk_round), 128'(0));
        check("midrst_rk", rk, 128'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        key_in = K2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_round", 128'(rk_round), 128'(0));
        check("post_rst_rk", rk, K2);
        wait_round(10);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
